// File: rtl/cipher_arbiter.sv
// cipher_arbiter: shares one stream_cipher core between two byte channels.
// Ports: clk, rst_n; per channel chN_key/_key_load/_req/_din in,
//        chN_ack/_dout/_dout_valid out; core_key/_key_in/_din/_din_valid
//        out to the core; core_dout/_dout_valid in from the core.
module cipher_arbiter #(
    parameter int BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ch0_key,
    input  logic       ch0_key_load,
    input  logic       ch0_req,
    input  logic [7:0] ch0_din,
    output logic       ch0_ack,
    output logic [7:0] ch0_dout,
    output logic       ch0_dout_valid,
    input  logic [7:0] ch1_key,
    input  logic       ch1_key_load,
    input  logic       ch1_req,
    input  logic [7:0] ch1_din,
    output logic       ch1_ack,
    output logic [7:0] ch1_dout,
    output logic       ch1_dout_valid,
    output logic [7:0] core_key,
    output logic       core_key_in,
    output logic [7:0] core_din,
    output logic       core_din_valid,
    input  logic [7:0] core_dout,
    input  logic       core_dout_valid
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0][7:0] ctx_q;
    logic [1:0][7:0] key;
    logic [1:0]      key_ok_q;
    logic [1:0]      req, kload, elig;
    logic            owner_vld_q, owner_q;
    logic            sel_q, sel_d, rr_q;
    logic [7:0]      burst_q;
    logic [8:0]      burst_inc;
    logic            iss_q, tag_q;
    logic            issue, exit_s, load_cyc;

    assign req       = {ch1_req, ch0_req};
    assign kload     = {ch1_key_load, ch0_key_load};
    assign key       = {ch1_key, ch0_key};
    assign elig      = req & key_ok_q & ~kload;
    assign burst_inc = {1'b0, burst_q} + 9'd1;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        issue    = 1'b0;
        exit_s   = 1'b0;
        load_cyc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|elig) begin
                    // tie goes to the channel not served last
                    sel_d   = (&elig) ? ~rr_q : elig[1];
                    state_d = (owner_vld_q && owner_q == sel_d) ? STREAM : LOAD;
                end
            end
            LOAD: begin
                load_cyc = 1'b1;
                // a key load racing the reload leaves the core stale
                state_d  = kload[sel_q] ? IDLE : STREAM;
            end
            STREAM: begin
                if (req[sel_q] && !kload[sel_q]) begin
                    issue  = 1'b1;
                    exit_s = (burst_inc >= 9'(BURST_LEN)) && elig[~sel_q];
                end else begin
                    exit_s = 1'b1;
                end
                if (exit_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ctx_q       <= '0;
            key_ok_q    <= '0;
            owner_vld_q <= 1'b0;
            owner_q     <= 1'b0;
            sel_q       <= 1'b0;
            rr_q        <= 1'b1;
            burst_q     <= '0;
            iss_q       <= 1'b0;
            tag_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            iss_q   <= issue;
            if (issue) tag_q <= sel_q;
            if (exit_s) begin
                rr_q    <= sel_q;
                burst_q <= '0;
            end else if (issue && burst_q != 8'hFF) begin
                burst_q <= burst_q + 8'd1;
            end
            for (int n = 0; n < 2; n++) begin
                if (kload[n]) begin
                    ctx_q[n]    <= key[n];
                    key_ok_q[n] <= 1'b1;
                end else if (issue && sel_q == 1'(n)) begin
                    ctx_q[n] <= ctx_q[n] + 8'd1;
                end
            end
            if (load_cyc) begin
                owner_vld_q <= !kload[sel_q];
                owner_q     <= sel_q;
            end else if (owner_vld_q && kload[owner_q]) begin
                owner_vld_q <= 1'b0;
            end
        end
    end

    assign ch0_ack        = issue & ~sel_q;
    assign ch1_ack        = issue & sel_q;
    assign core_key_in    = load_cyc;
    assign core_key       = load_cyc ? ctx_q[sel_q] : 8'h00;
    assign core_din_valid = issue;
    assign core_din       = issue ? (sel_q ? ch1_din : ch0_din) : 8'h00;
    // core_dout_valid lingers across key_in, so routing uses iss_q
    assign ch0_dout       = core_dout;
    assign ch1_dout       = core_dout;
    assign ch0_dout_valid = iss_q & ~tag_q;
    assign ch1_dout_valid = iss_q & tag_q;

    a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
        !(core_key_in && core_din_valid));
    a_core_ret: assert property (@(posedge clk) disable iff (!rst_n)
        iss_q |-> core_dout_valid);
endmodule

// File: tb/tb_cipher_arbiter.sv
// tb_cipher_arbiter: cipher_arbiter with a behavioural stream_cipher core
// and a per-channel keystream scoreboard.
module tb_cipher_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_v, load_v, ack_v, dv_v;
    logic [7:0] key_v [2];
    logic [7:0] din_v [2];
    logic [7:0] dout_v [2];
    logic [7:0] core_key, core_din, core_dout;
    logic       core_key_in, core_din_valid, core_dout_valid;

    int checks = 0;
    int failures = 0;

    logic [7:0] mctr [2];
    bit         mkey_ok [2];
    logic [7:0] expq [2][$];
    logic [7:0] obs_keys [$];
    logic [7:0] obs_din [$];
    logic [7:0] obs_dout [$];

    always #5 clk = ~clk;

    cipher_arbiter #(.BURST_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ch0_key(key_v[0]), .ch0_key_load(load_v[0]), .ch0_req(req_v[0]),
        .ch0_din(din_v[0]), .ch0_ack(ack_v[0]), .ch0_dout(dout_v[0]),
        .ch0_dout_valid(dv_v[0]),
        .ch1_key(key_v[1]), .ch1_key_load(load_v[1]), .ch1_req(req_v[1]),
        .ch1_din(din_v[1]), .ch1_ack(ack_v[1]), .ch1_dout(dout_v[1]),
        .ch1_dout_valid(dv_v[1]),
        .core_key(core_key), .core_key_in(core_key_in),
        .core_din(core_din), .core_din_valid(core_din_valid),
        .core_dout(core_dout), .core_dout_valid(core_dout_valid)
    );

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] m;
        m = x * 8'd29;
        return {x[2:0], x[7:3]} ^ m ^ 8'h63;
    endfunction

    // stream_cipher core: counter-mode keystream, 1-cycle output
    logic [7:0] cctr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cctr <= 8'h00;
            core_dout <= 8'h00;
            core_dout_valid <= 1'b0;
        end else begin
            if (core_key_in) begin
                cctr <= core_key;
            end else if (core_din_valid) begin
                core_dout <= core_din ^ sbox(cctr);
                cctr <= cctr + 8'd1;
            end
            core_dout_valid <= core_din_valid | (core_dout_valid & core_key_in);
        end
    end

    // scoreboard: each channel owns a private counter from its last key
    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checks++;
                if (core_key_in && core_din_valid) begin
                    failures++;
                    $display("FAIL key_din_overlap got=both exp=not_both");
                end
                checks++;
                if (ack_v == 2'b11) begin
                    failures++;
                    $display("FAIL dual_ack got=%b exp=one_hot", ack_v);
                end
                for (int n = 0; n < 2; n++) begin
                    if (dv_v[n]) begin
                        checks++;
                        if (expq[n].size() == 0) begin
                            failures++;
                            $display("FAIL ch%0d_spurious_dout got=%h exp=none", n, dout_v[n]);
                        end else begin
                            e = expq[n].pop_front();
                            if (dout_v[n] !== e) begin
                                failures++;
                                $display("FAIL ch%0d_dout got=%h exp=%h", n, dout_v[n], e);
                            end
                        end
                    end
                    if (ack_v[n]) begin
                        checks++;
                        if (!mkey_ok[n] || load_v[n]) begin
                            failures++;
                            $display("FAIL ch%0d_ack_illegal got=1 exp=0", n);
                        end
                        expq[n].push_back(din_v[n] ^ sbox(mctr[n]));
                        mctr[n] = mctr[n] + 8'd1;
                    end
                    if (load_v[n]) begin
                        mctr[n] = key_v[n];
                        mkey_ok[n] = 1'b1;
                    end
                end
            end
        end
    end

    function automatic logic [37:0] outs();
        return {ack_v, dv_v, dout_v[0], dout_v[1], core_key, core_key_in,
                core_din, core_din_valid};
    endfunction

    function automatic string ev();
        if (core_key_in) return "L";
        if (ack_v[0]) return "0";
        if (ack_v[1]) return "1";
        return "I";
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        req_v = '0;
        load_v = '0;
        rst_n = 1'b0;
        for (int n = 0; n < 2; n++) begin
            expq[n].delete();
            mctr[n] = 8'h00;
            mkey_ok[n] = 1'b0;
        end
        tick(3);
        rst_n = 1'b1;
    endtask

    task automatic load_key(input bit ch, input logic [7:0] k);
        key_v[ch] = k;
        load_v[ch] = 1'b1;
        tick(1);
        load_v[ch] = 1'b0;
    endtask

    task automatic drive_bytes(input bit ch, input int n, input bit rnd,
                               input bit hold, output string seq);
        int acks;
        int c;
        acks = 0;
        c = 0;
        seq = "";
        obs_keys.delete();
        obs_din.delete();
        obs_dout.delete();
        din_v[ch] = rnd ? 8'($urandom) : 8'h00;
        req_v[ch] = 1'b1;
        while (acks < n && c < 40) begin
            @(negedge clk);
            seq = {seq, ev()};
            if (core_key_in) obs_keys.push_back(core_key);
            if (dv_v[ch]) obs_dout.push_back(dout_v[ch]);
            if (ack_v[ch]) begin
                acks++;
                obs_din.push_back(din_v[ch]);
            end
            tick(1);
            din_v[ch] = rnd ? 8'($urandom) : 8'h00;
            c++;
        end
        if (!hold) begin
            req_v[ch] = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (dv_v[ch]) obs_dout.push_back(dout_v[ch]);
                tick(1);
            end
        end
    endtask

    task automatic test_reset();
        tick(2);
        checks++;
        if (outs() !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", outs());
        end
        apply_reset();
    endtask

    task automatic test_burst();
        string seq;
        key_v[0] = 8'h10;
        key_v[1] = 8'h80;
        load_v = 2'b11;
        tick(1);
        load_v = '0;
        req_v = 2'b11;
        seq = "";
        obs_keys.delete();
        for (int c = 0; c < 15; c++) begin
            din_v[0] = 8'($urandom);
            din_v[1] = 8'($urandom);
            @(negedge clk);
            seq = {seq, ev()};
            if (core_key_in) obs_keys.push_back(core_key);
            tick(1);
        end
        req_v = '0;
        tick(3);
        checks++;
        if (seq != "IL0000IL1111IL0") begin
            failures++;
            $display("FAIL burst_order got=%s exp=IL0000IL1111IL0", seq);
        end
        checks++;
        if (obs_keys.size() != 3 || obs_keys[0] !== 8'h10 ||
            obs_keys[1] !== 8'h80 || obs_keys[2] !== 8'h14) begin
            failures++;
            $display("FAIL burst_keys got=%0d keys exp=10,80,14", obs_keys.size());
        end
    endtask

    task automatic test_wrap();
        string seq;
        logic [7:0] k;
        load_key(1'b0, 8'hFE);
        drive_bytes(1'b0, 3, 1'b0, 1'b0, seq);
        checks++;
        if (seq != "IL000") begin
            failures++;
            $display("FAIL wrap_seq got=%s exp=IL000", seq);
        end
        checks++;
        if (obs_keys.size() != 1 || obs_keys[0] !== 8'hFE) begin
            failures++;
            $display("FAIL wrap_key got=%0d keys exp=FE", obs_keys.size());
        end
        for (int i = 0; i < 3; i++) begin
            k = 8'hFE + 8'(i);
            checks++;
            if (i >= obs_dout.size() || obs_dout[i] !== sbox(k)) begin
                failures++;
                $display("FAIL wrap_dout%0d got=%0d bytes exp=%h", i, obs_dout.size(), sbox(k));
            end
        end
        drive_bytes(1'b0, 1, 1'b1, 1'b0, seq);
        checks++;
        if (seq != "I0" || obs_keys.size() != 0) begin
            failures++;
            $display("FAIL wrap_next_seq got=%s exp=I0", seq);
        end
        checks++;
        if (obs_dout.size() != 1 || obs_dout[0] !== (obs_din[0] ^ sbox(8'h01))) begin
            failures++;
            $display("FAIL wrap_ctx01 got=%0d bytes exp=%h", obs_dout.size(), obs_din[0] ^ sbox(8'h01));
        end
    endtask

    task automatic test_resume();
        string seq;
        drive_bytes(1'b1, 2, 1'b1, 1'b0, seq);
        checks++;
        if (seq != "IL11" || obs_keys.size() != 1 || obs_keys[0] !== 8'h84) begin
            failures++;
            $display("FAIL resume_first got=%s exp=IL11 key 84", seq);
        end
        drive_bytes(1'b1, 1, 1'b1, 1'b0, seq);
        checks++;
        if (seq != "I1" || obs_keys.size() != 0) begin
            failures++;
            $display("FAIL resume_noload got=%s exp=I1", seq);
        end
        checks++;
        if (obs_dout.size() != 1 || obs_dout[0] !== (obs_din[0] ^ sbox(8'h86))) begin
            failures++;
            $display("FAIL resume_ctr got=%0d bytes exp=%h", obs_dout.size(), obs_din[0] ^ sbox(8'h86));
        end
    endtask

    task automatic test_keyload_stream();
        string seq;
        drive_bytes(1'b0, 2, 1'b1, 1'b1, seq);
        checks++;
        if (seq != "IL00" || obs_keys.size() != 1 || obs_keys[0] !== 8'h02) begin
            failures++;
            $display("FAIL kl_prefix got=%s exp=IL00 key 02", seq);
        end
        key_v[0] = 8'h33;
        load_v[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (ack_v[0] !== 1'b0 || core_din_valid !== 1'b0) begin
            failures++;
            $display("FAIL kl_no_ack got=%b exp=0", ack_v[0]);
        end
        tick(1);
        load_v[0] = 1'b0;
        drive_bytes(1'b0, 1, 1'b1, 1'b0, seq);
        checks++;
        if (seq != "IL0" || obs_keys.size() != 1 || obs_keys[0] !== 8'h33) begin
            failures++;
            $display("FAIL kl_reload got=%s exp=IL0 key 33", seq);
        end
        checks++;
        if (obs_dout.size() != 1 || obs_dout[0] !== (obs_din[0] ^ sbox(8'h33))) begin
            failures++;
            $display("FAIL kl_dout got=%0d bytes exp=%h", obs_dout.size(), obs_din[0] ^ sbox(8'h33));
        end
    endtask

    task automatic test_mid_reset();
        string seq;
        drive_bytes(1'b0, 1, 1'b1, 1'b1, seq);
        checks++;
        if (seq != "I0") begin
            failures++;
            $display("FAIL mr_stream got=%s exp=I0", seq);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== '0) begin
            failures++;
            $display("FAIL mr_async_zero got=%h exp=0", outs());
        end
        apply_reset();
    endtask

    task automatic test_no_key();
        int active;
        active = 0;
        req_v = 2'b11;
        for (int c = 0; c < 12; c++) begin
            din_v[0] = 8'($urandom);
            din_v[1] = 8'($urandom);
            @(negedge clk);
            if (|ack_v || core_din_valid || core_key_in) active++;
            tick(1);
        end
        req_v = '0;
        checks++;
        if (active != 0) begin
            failures++;
            $display("FAIL nokey_idle got=%0d exp=0", active);
        end
    endtask

    task automatic test_after_reset();
        string seq;
        load_key(1'b0, 8'h00);
        drive_bytes(1'b0, 1, 1'b1, 1'b0, seq);
        checks++;
        if (seq != "IL0" || obs_keys.size() != 1 || obs_keys[0] !== 8'h00) begin
            failures++;
            $display("FAIL post_reset_load got=%s exp=IL0 key 00", seq);
        end
        checks++;
        if (obs_dout.size() != 1 || obs_dout[0] !== (obs_din[0] ^ sbox(8'h00))) begin
            failures++;
            $display("FAIL post_reset_dout got=%0d bytes exp=%h", obs_dout.size(), obs_din[0] ^ sbox(8'h00));
        end
    endtask

    task automatic test_random();
        int acks;
        acks = 0;
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < 2; n++) begin
                req_v[n] = ($urandom_range(3) != 0);
                din_v[n] = 8'($urandom);
                key_v[n] = 8'($urandom);
                load_v[n] = ($urandom_range(15) == 0);
            end
            @(negedge clk);
            if (|ack_v) acks++;
            tick(1);
        end
        req_v = '0;
        load_v = '0;
        tick(4);
        checks++;
        if (expq[0].size() != 0 || expq[1].size() != 0) begin
            failures++;
            $display("FAIL rand_drain got=%0d/%0d exp=0/0", expq[0].size(), expq[1].size());
        end
        checks++;
        if (acks < 80) begin
            failures++;
            $display("FAIL rand_throughput got=%0d exp>=80", acks);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_v = '0;
        load_v = '0;
        key_v[0] = 8'h00;
        key_v[1] = 8'h00;
        din_v[0] = 8'h00;
        din_v[1] = 8'h00;
        test_reset();
        test_burst();
        test_wrap();
        test_resume();
        test_keyload_stream();
        test_mid_reset();
        test_no_key();
        test_after_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
